// File: rtl/bank_copy_dma.sv
// bank_copy_dma: single-channel word mover between four packed bank memories.
// Each word costs one read cycle (RD) and one write cycle (WR). The copy runs
// in strictly ascending order, so same-bank overlapping ranges get forward-copy
// semantics.
// Optional feature: define DMA_FILL_EN to enable constant-fill transfers.
// A fill skips RD and writes fill_data once per cycle.
module bank_copy_dma #(
    parameter int WIDTH = 36
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         src_bank,
    input  logic [1:0]         dst_bank,
    input  logic [9:0]         src_addr,
    input  logic [9:0]         dst_addr,
    input  logic [10:0]        len,
    input  logic               fill_mode,
    input  logic [WIDTH-1:0]   fill_data,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [3:0]         mem_we,
    output logic [WIDTH*4-1:0] mem_a,
    output logic [WIDTH*4-1:0] mem_wd,
    input  logic [WIDTH*4-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [1:0]       sbank, dbank;
    logic [9:0]       src_ptr, dst_ptr;
    logic [10:0]      cnt;
    logic [WIDTH-1:0] data_reg;
    logic             err_r;
    logic             fill_req;
    logic             fill_r;
    logic [11:0]      src_end, dst_end;
    logic             range_bad;

    // Bank depths are fixed by the memory system, not by WIDTH.
    function automatic logic [11:0] bank_depth(input logic [1:0] b);
        case (b)
            2'd0:    return 12'd1024;
            2'd1:    return 12'd32;
            2'd2:    return 12'd1024;
            default: return 12'd750;
        endcase
    endfunction

`ifdef DMA_FILL_EN
    assign fill_req = fill_mode;
`else
    // Fill controls have no effect in this build; every transfer is a copy.
    logic unused_fill;
    assign fill_req    = 1'b0;
    assign fill_r      = 1'b0;
    assign unused_fill = ^{fill_mode, fill_data};
`endif

    // The end address is one past the last word. It must not exceed the bank depth.
    assign src_end   = {2'b00, src_addr} + {1'b0, len};
    assign dst_end   = {2'b00, dst_addr} + {1'b0, len};
    assign range_bad = (dst_end > bank_depth(dst_bank)) ||
                       (!fill_req && (src_end > bank_depth(src_bank)));

    // State register; err is a registered one-cycle pulse after a rejected request
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err_r <= 1'b0;
        end else begin
            state <= state_next;
            err_r <= (state == IDLE) && start && range_bad;
        end
    end

    // Next-state decode; start is only looked at in IDLE, so it is never queued
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && !range_bad) begin
                    if (len == 11'd0)
                        state_next = FIN;
                    else if (fill_req)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:  state_next = WR;
            WR: begin
                // cnt still holds the count before this word is retired.
                if (cnt > 11'd1)
                    state_next = fill_r ? WR : RD;
                else
                    state_next = FIN;
            end
            FIN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory-side outputs decode only from registered state and registers
    always_comb begin
        mem_we = '0;
        mem_a  = '0;
        mem_wd = '0;
        busy   = (state != IDLE);
        done   = (state == FIN);
        case (state)
            RD: begin
                mem_a[int'(sbank)*WIDTH +: WIDTH] = WIDTH'(src_ptr);
            end
            WR: begin
                mem_a[int'(dbank)*WIDTH +: WIDTH]  = WIDTH'(dst_ptr);
                mem_wd[int'(dbank)*WIDTH +: WIDTH] = data_reg;
                mem_we[dbank]                      = 1'b1;
            end
            default: ;
        endcase
    end

    assign err = err_r;

    // Request latch, pointer/count advance and read-data capture
    always_ff @(posedge clk) begin
        if (reset) begin
            sbank    <= 2'd0;
            dbank    <= 2'd0;
            src_ptr  <= 10'd0;
            dst_ptr  <= 10'd0;
            cnt      <= 11'd0;
            data_reg <= '0;
`ifdef DMA_FILL_EN
            fill_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sbank    <= src_bank;
                        dbank    <= dst_bank;
                        src_ptr  <= src_addr;
                        dst_ptr  <= dst_addr;
                        cnt      <= len;
`ifdef DMA_FILL_EN
                        // A copy overwrites data_reg in RD, so loading the pattern is harmless.
                        fill_r   <= fill_mode;
                        data_reg <= fill_data;
`endif
                    end
                end
                RD: begin
                    data_reg <= mem_rd[int'(sbank)*WIDTH +: WIDTH];
                end
                WR: begin
                    src_ptr <= src_ptr + 10'd1;
                    dst_ptr <= dst_ptr + 10'd1;
                    cnt     <= cnt - 11'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_copy_dma.sv
// tb_bank_copy_dma: table-driven, hand-written and randomized checks of
// bank_copy_dma. The bench models the four bank memories around the DUT.
// It compares them with a reference image built from the transfer rules.
module tb_bank_copy_dma;

    localparam int W = 36;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     src_bank, dst_bank;
    logic [9:0]     src_addr, dst_addr;
    logic [10:0]    len;
    logic           fill_mode;
    logic [W-1:0]   fill_data;
    logic           busy, done, err;
    logic [3:0]     mem_we;
    logic [W*4-1:0] mem_a, mem_wd, mem_rd;

    bank_copy_dma #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_bank(src_bank), .dst_bank(dst_bank),
        .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .fill_mode(fill_mode), .fill_data(fill_data),
        .busy(busy), .done(done), .err(err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Bank memories seen by the DUT, plus the reference image
    logic [W-1:0] tb_mem  [4][1024];
    logic [W-1:0] ref_mem [4][1024];
    logic         init_req = 1'b0;
    logic         bd_we    = 1'b0;
    logic [1:0]   bd_bank  = 2'd0;
    logic [9:0]   bd_addr  = 10'd0;
    logic [W-1:0] bd_data  = '0;

    int n_vec = 0;
    int n_bad = 0;

    function automatic logic [W-1:0] pat(input int k, input int i);
        return W'({4'(k), 32'(i * 32'h2545F491 + 7)});
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 4; k++)
                for (int i = 0; i < 1024; i++)
                    tb_mem[k][i] <= pat(k, i);
        end
        if (bd_we) tb_mem[bd_bank][bd_addr] <= bd_data;
        for (int k = 0; k < 4; k++)
            if (mem_we[k]) tb_mem[k][mem_a[W*k +: 10]] <= mem_wd[W*k +: W];
    end

    always_comb begin
        mem_rd = '0;
        for (int k = 0; k < 4; k++)
            mem_rd[W*k +: W] = tb_mem[k][mem_a[W*k +: 10]];
    end

    // ---------------- reference model ----------------
    function automatic int depth_of(input logic [1:0] b);
        case (b)
            2'd0: return 1024;
            2'd1: return 32;
            2'd2: return 1024;
            default: return 750;
        endcase
    endfunction

    function automatic bit fill_eff(input logic fm);
`ifdef DMA_FILL_EN
        return fm;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_err(input logic [1:0] sb, input logic [9:0] sa,
                                     input logic [1:0] db, input logic [9:0] da,
                                     input logic [10:0] ln, input logic fm);
        if (int'(da) + int'(ln) > depth_of(db)) return 1'b1;
        if (!fill_eff(fm) && (int'(sa) + int'(ln) > depth_of(sb))) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_lat(input logic [10:0] ln, input logic fm);
        if (ln == 0) return 1;
        if (fill_eff(fm)) return int'(ln) + 1;
        return 2 * int'(ln) + 1;
    endfunction

    // Words are applied one at a time in ascending order, giving forward-copy results.
    function automatic void ref_apply(input logic [1:0] sb, input logic [9:0] sa,
                                      input logic [1:0] db, input logic [9:0] da,
                                      input logic fm, input logic [W-1:0] fd,
                                      input int nwords);
        for (int i = 0; i < nwords; i++) begin
            if (fill_eff(fm)) ref_mem[db][int'(da) + i] = fd;
            else              ref_mem[db][int'(da) + i] = ref_mem[sb][int'(sa) + i];
        end
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_cmp(input string nm);
        int bad = 0;
        int fk = 0;
        int fi = 0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 1024; i++)
                if (tb_mem[k][i] !== ref_mem[k][i]) begin
                    if (bad == 0) begin fk = k; fi = i; end
                    bad++;
                end
        n_vec++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_mem: %0d words differ, first bank%0d[%0d] got %0h expected %0h",
                     nm, bad, fk, fi, tb_mem[fk][fi], ref_mem[fk][fi]);
        end
    endtask

    task automatic preload(input logic [1:0] k, input logic [9:0] a, input logic [W-1:0] d);
        bd_we = 1'b1; bd_bank = k; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[k][a] = d;
    endtask

    // Issue one request and observe a bounded window afterwards.
    // poke > 0 re-asserts start during that cycle of the transfer.
    task automatic run_txn(input string nm,
                           input logic [1:0] sb, input logic [9:0] sa,
                           input logic [1:0] db, input logic [9:0] da,
                           input logic [10:0] ln, input logic fm, input logic [W-1:0] fd,
                           input logic exp_err, input int exp_lat, input int poke);
        int done_at = -1, done_cnt = 0, err_at = -1, err_cnt = 0;
        int we_cnt = 0, we_bad = 0, busy_bad = 0, win;
        src_bank = sb; src_addr = sa; dst_bank = db; dst_addr = da;
        len = ln; fill_mode = fm; fill_data = fd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        win = exp_err ? 3 : exp_lat + 2;
        for (int c = 1; c <= win; c++) begin
            if (done) begin done_cnt++; if (done_at < 0) done_at = c; end
            if (err)  begin err_cnt++;  if (err_at < 0)  err_at = c;  end
            if (mem_we != 4'd0) we_cnt++;
            if (mem_we != 4'd0 && mem_we != (4'b0001 << db)) we_bad++;
            if (ln != 0 && busy !== (!exp_err && c <= exp_lat)) busy_bad++;
            if (c == poke) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (exp_err) begin
            chk({nm, "_err_at"},   64'(err_at),   64'(1));
            chk({nm, "_err_cnt"},  64'(err_cnt),  64'(1));
            chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(0));
            chk({nm, "_we_cnt"},   64'(we_cnt),   64'(0));
            chk({nm, "_busy"},     64'(busy_bad), 64'(0));
        end else begin
            chk({nm, "_done_at"},  64'(done_at),  64'(exp_lat));
            chk({nm, "_done_cnt"}, 64'(done_cnt), 64'(1));
            chk({nm, "_err_cnt"},  64'(err_cnt),  64'(0));
            chk({nm, "_we_cnt"},   64'(we_cnt),   64'(ln));
            chk({nm, "_we_hot"},   64'(we_bad),   64'(0));
            chk({nm, "_busy"},     64'(busy_bad), 64'(0));
            ref_apply(sb, sa, db, da, fm, fd, int'(ln));
        end
        mem_cmp(nm);
    endtask

    typedef struct {
        string        nm;
        logic [1:0]   sb;
        logic [9:0]   sa;
        logic [1:0]   db;
        logic [9:0]   da;
        logic [10:0]  ln;
        logic         fm;
        logic [W-1:0] fd;
        logic         exp_err;
        int           exp_lat;
        int           poke;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int wc;
        reset = 1'b1; start = 1'b0;
        src_bank = '0; dst_bank = '0; src_addr = '0; dst_addr = '0;
        len = '0; fill_mode = 1'b0; fill_data = '0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 1024; i++)
                ref_mem[k][i] = pat(k, i);
        init_req = 1'b1;
        @(posedge clk); #1;
        init_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy",   64'(busy),   64'(0));
        chk("rst_done",   64'(done),   64'(0));
        chk("rst_err",    64'(err),    64'(0));
        chk("rst_we",     64'(mem_we), 64'(0));
        chk("rst_a_zero", 64'(mem_a == '0),  64'(1));
        chk("rst_wd_zero",64'(mem_wd == '0), 64'(1));
        reset = 1'b0;

        preload(2'd3, 10'd5, 36'd1);
        preload(2'd3, 10'd6, 36'd2);
        preload(2'd3, 10'd7, 36'd3);
        preload(2'd3, 10'd8, 36'd4);
        preload(2'd0, 10'd0, 36'hA);
        preload(2'd0, 10'd1, 36'hB);
        preload(2'd0, 10'd2, 36'hC);
        preload(2'd0, 10'd3, 36'hD);

        vecs[0] = '{"copy4",     2'd3, 10'd5,   2'd1, 10'd0,   11'd4,    1'b0, 36'h0,   1'b0, 9,    5};
        vecs[1] = '{"dst_range", 2'd0, 10'd0,   2'd1, 10'd30,  11'd3,    1'b0, 36'h0,   1'b1, 0,    0};
        vecs[2] = '{"len0",      2'd0, 10'd0,   2'd2, 10'd0,   11'd0,    1'b0, 36'h0,   1'b0, 1,    0};
        vecs[3] = '{"overlap",   2'd0, 10'd0,   2'd0, 10'd1,   11'd3,    1'b0, 36'h0,   1'b0, 7,    0};
        vecs[4] = '{"src_range", 2'd3, 10'd749, 2'd2, 10'd0,   11'd2,    1'b0, 36'h0,   1'b1, 0,    0};
        vecs[5] = '{"b3_edge",   2'd2, 10'd0,   2'd3, 10'd745, 11'd5,    1'b0, 36'h0,   1'b0, 11,   0};
        vecs[6] = '{"b1_last",   2'd0, 10'd100, 2'd1, 10'd31,  11'd1,    1'b0, 36'h0,   1'b0, 3,    0};
        vecs[7] = '{"b1_over",   2'd0, 10'd100, 2'd1, 10'd31,  11'd2,    1'b0, 36'h0,   1'b1, 0,    0};
`ifdef DMA_FILL_EN
        vecs[8] = '{"fill10",    2'd3, 10'd0,   2'd3, 10'd740, 11'd10,   1'b1, 36'h5A5, 1'b0, 11,   3};
`else
        vecs[8] = '{"fill10",    2'd3, 10'd0,   2'd3, 10'd740, 11'd10,   1'b1, 36'h5A5, 1'b0, 21,   3};
`endif
        vecs[9] = '{"full1024",  2'd0, 10'd0,   2'd2, 10'd0,   11'd1024, 1'b0, 36'h0,   1'b0, 2049, 0};

        foreach (vecs[v])
            run_txn(vecs[v].nm, vecs[v].sb, vecs[v].sa, vecs[v].db, vecs[v].da,
                    vecs[v].ln, vecs[v].fm, vecs[v].fd, vecs[v].exp_err,
                    vecs[v].exp_lat, vecs[v].poke);

        // Absolute results of the hand-written scenarios.
        for (int i = 0; i < 4; i++)
            chk($sformatf("copy4_bank1_%0d", i), 64'(tb_mem[1][i]), 64'(i + 1));
        for (int i = 0; i < 4; i++)
            chk($sformatf("overlap_bank0_%0d", i), 64'(tb_mem[0][i]), 64'h0A);
`ifdef DMA_FILL_EN
        for (int i = 740; i < 750; i++)
            chk($sformatf("fill_bank3_%0d", i), 64'(tb_mem[3][i]), 64'h5A5);
`endif

        // Reset in cycle 4 of a 4-word copy: two words land, nothing resumes
        src_bank = 2'd2; src_addr = 10'd10; dst_bank = 2'd2; dst_addr = 10'd500;
        len = 11'd4; fill_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wc = 0;
        for (int c = 1; c <= 4; c++) begin
            if (mem_we != 4'd0) wc++;
            if (c == 4) reset = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        chk("abort_writes", 64'(wc),     64'(2));
        chk("abort_busy",   64'(busy),   64'(0));
        chk("abort_done",   64'(done),   64'(0));
        chk("abort_we",     64'(mem_we), 64'(0));
        chk("abort_a_zero", 64'(mem_a == '0), 64'(1));
        ref_apply(2'd2, 10'd10, 2'd2, 10'd500, 1'b0, '0, 2);
        repeat (10) begin
            @(posedge clk); #1;
            if (busy || mem_we != 4'd0) wc++;
        end
        chk("abort_no_resume", 64'(wc), 64'(2));
        mem_cmp("abort");
        run_txn("after_abort", 2'd0, 10'd200, 2'd2, 10'd900, 11'd6, 1'b0, '0, 1'b0, 13, 0);

        // Randomized transfers against the reference model
        for (int t = 0; t < 30; t++) begin
            logic [1:0]   sb, db;
            logic [9:0]   sa, da;
            logic [10:0]  ln;
            logic         fm, e;
            logic [W-1:0] fd;
            int           lat, pk;
            sb = 2'($urandom_range(0, 3));
            db = 2'($urandom_range(0, 3));
            sa = 10'($urandom_range(0, depth_of(sb) - 1));
            da = 10'($urandom_range(0, depth_of(db) - 1));
            ln = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom_range(1, 15));
            fm = 1'($urandom_range(0, 1));
            fd = W'({$urandom(), $urandom()});
            e   = model_err(sb, sa, db, da, ln, fm);
            lat = model_lat(ln, fm);
            pk  = (e || ln == 0) ? 0 : int'($urandom_range(1, lat));
            run_txn($sformatf("rnd%0d", t), sb, sa, db, da, ln, fm, fd, e, lat, pk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bank_copy_dma.md
BANK_COPY_DMA -- requirements
Module: bank_copy_dma

Interface
REQ-001 SHALL have parameter WIDTH, default 36: width of each bank slice on the packed memory buses.
REQ-002 SHALL have port clk  in  1: single clock; all state updates on posedge.
REQ-003 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-004 SHALL have port start  in  1: transfer request, sampled only in IDLE.
REQ-005 SHALL have ports src_bank, dst_bank  in  2 each: bank index 0..3.
REQ-006 SHALL have ports src_addr, dst_addr  in  10 each: first word address.
REQ-007 SHALL have port len  in  11: word count, 0..1024.
REQ-008 SHALL have ports fill_mode  in  1 and fill_data  in  WIDTH: constant-fill request and pattern.
REQ-009 SHALL have ports busy  out  1, done  out  1 and err  out  1: status outputs.
REQ-010 SHALL have ports mem_we  out  4, mem_a  out  WIDTH*4 and mem_wd  out  WIDTH*4: packed bank-memory controls; bank k occupies bits [WIDTH*(k+1)-1:WIDTH*k].
REQ-011 SHALL have port mem_rd  in  WIDTH*4: combinational read data from the bank memory.

Function
REQ-012 SHALL implement the states IDLE, RD, WR and FIN.
REQ-013 In IDLE with start=1, SHALL latch all request fields and range-check against bank depths {1024,32,1024,750}.
REQ-014 Range failure (addr+len > depth for src or dst) SHALL give a 1-cycle err pulse on the next cycle, stay in IDLE and issue no writes.
REQ-015 len=0 SHALL go to FIN (done pulse next cycle) with no memory activity.
REQ-016 Otherwise SHALL go to RD, busy=1 from the cycle after acceptance until FIN exits.
REQ-017 RD: mem_a src slice = zero-extended src pointer, all other slices 0, mem_we=0; SHALL capture the src slice of mem_rd into the data register at the clock edge ending RD.
REQ-018 WR: mem_a dst slice = dst pointer, mem_wd dst slice = data register, mem_we one-hot on dst_bank, other slices 0; both pointers increment by 1 and the remaining count decrements at the edge ending WR.
REQ-019 After WR SHALL go to RD if remaining>0, else FIN; FIN SHALL assert done for exactly 1 cycle, then return to IDLE.
REQ-020 Total latency from the accept edge to the done cycle SHALL be 2*len+1 cycles.
REQ-021 mem_we, mem_a and mem_wd SHALL decode from registered state only, with no combinational path from start or mem_rd.
REQ-022 Copy order SHALL be strictly ascending; same-bank overlapping ranges SHALL give forward-copy semantics (not memmove).
REQ-023 start while not IDLE SHALL be ignored; it SHALL NOT be queued.
REQ-024 Data SHALL be passed as the full WIDTH bits; narrower banks truncate on write, which the block SHALL NOT compensate.

Reset
REQ-025 reset SHALL force IDLE at the next posedge, including mid-transfer; busy, done, err and mem_we SHALL be 0 from that edge.
REQ-026 reset SHALL zero mem_a, mem_wd, the pointers, the count and the data register.
REQ-027 A transfer aborted by reset SHALL NOT resume; words already written remain.

Configuration
REQ-028 With macro DMA_FILL_EN defined: fill_mode=1 at accept SHALL skip RD, write fill_data on every WR with 1 cycle per word, and give latency len+1; src fields SHALL be ignored and src range SHALL NOT be checked.
REQ-029 Without DMA_FILL_EN: fill_mode and fill_data SHALL be ignored, and every transfer SHALL be a copy.

Verification
REQ-030 Copy: bank3 addr 5..8 = {1,2,3,4}, start src=3/5, dst=1/0, len=4 -> bank1[0..3]={1,2,3,4}; done at cycle 9 after accept; busy high cycles 1..9.
REQ-031 Range: dst_bank=1, dst_addr=30, len=3 -> err pulse next cycle, mem_we never asserted, busy stays 0.
REQ-032 len=0 -> done 1 cycle after accept, mem_we stays 0.
REQ-033 Overlap: bank0[0..3]={A,B,C,D}, copy src 0 -> dst 1, len=3 -> bank0[0..3]={A,A,A,A}.
REQ-034 Reset at cycle 4 of a len=4 copy -> 2 words written, busy=0 at the next edge; a new start is accepted afterwards.
REQ-035 DMA_FILL_EN: fill_data=0x5A5, dst=3/740, len=10 -> bank3[740..749]=0x5A5; done at cycle 11; a second start while busy is ignored.
